mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_responder_ram.sv | 37 +++
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// State encoding follows Gray order so adjacent states differ by one bit.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int NLANES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b11,
        RESP  = 2'b10
    } state_e;

    // Misaligned, or beyond the implemented word range.
    function automatic logic addr_err(input logic [31:0] a, input int aw);
        logic [31:0] hi;
        hi = a >> (aw + 2);
        return (a[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM, 1-cycle read latency, per-lane writes.
// Contents are intentionally not reset.
module mem_responder_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [NLANES-1:0] be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (be[i]) begin
                        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fetch/data memory responder: arbitrates one transaction at a time.
// Optional byte-lane stores with MEM_RESPONDER_BYTE_WE_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [WORD_W-1:0] if_inst,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [WORD_W-1:0] d_wdata,
`ifdef MEM_RESPONDER_BYTE_WE_EN
    input  logic [NLANES-1:0] d_be,
`endif
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              err,
    output logic              busy
);

    state_e state_q, state_d;

    logic [AW-1:0]     widx_q, widx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [NLANES-1:0] be_q, be_d;
    logic              we_q, we_d;
    logic              sel_d_q, sel_d_d;
    logic              aerr_q, aerr_d;

    logic [WORD_W-1:0] if_inst_q, if_inst_d;
    logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              err_q, err_d;

    logic              ram_en;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;
    logic [NLANES-1:0] be_in;

`ifdef MEM_RESPONDER_BYTE_WE_EN
    assign be_in = d_be;
`else
    assign be_in = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        sel_d_d    = sel_d_q;
        aerr_d     = aerr_q;
        if_inst_d  = if_inst_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d = DATA;
                    sel_d_d = 1'b1;
                    widx_d  = d_addr[AW+1:2];
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    be_d    = be_in;
                    aerr_d  = addr_err(d_addr, AW);
                end else if (if_req) begin
                    state_d = FETCH;
                    sel_d_d = 1'b0;
                    widx_d  = if_addr[AW+1:2];
                    we_d    = 1'b0;
                    aerr_d  = addr_err(if_addr, AW);
                end
            end
            FETCH: begin
                ram_en  = 1'b1;
                state_d = RESP;
            end
            DATA: begin
                ram_en  = 1'b1;
                // Reset wins over a store landing in the same cycle.
                ram_we  = we_q && !aerr_q && !rst;
                state_d = RESP;
            end
            RESP: begin
                err_d = aerr_q;
                if (sel_d_q) begin
                    d_valid_d = 1'b1;
                    d_rdata_d = (we_q || aerr_q) ? '0 : ram_rdata;
                end else begin
                    if_valid_d = 1'b1;
                    if_inst_d  = aerr_q ? '0 : ram_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            widx_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            sel_d_q    <= 1'b0;
            aerr_q     <= 1'b0;
            if_inst_q  <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            sel_d_q    <= sel_d_d;
            aerr_q     <= aerr_d;
            if_inst_q  <= if_inst_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
        end
    end

    mem_responder_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .be   (be_q),
        .addr (widx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;
    assign d_rdata  = d_rdata_q;
    assign d_valid  = d_valid_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; byte-lane case runs only when
// MEM_RESPONDER_BYTE_WE_EN is defined.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        err;
    logic        busy;
`ifdef MEM_RESPONDER_BYTE_WE_EN
    logic [3:0]  d_be;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256)) dut (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_inst (if_inst),
        .if_valid(if_valid),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
`ifdef MEM_RESPONDER_BYTE_WE_EN
        .d_be    (d_be),
`endif
        .d_rdata (d_rdata),
        .d_valid (d_valid),
        .err     (err),
        .busy    (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Data transaction; returns edges from sampling edge to valid.
    task automatic xact_d(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int lat);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
`ifdef MEM_RESPONDER_BYTE_WE_EN
        d_be    = be;
`else
        if (be != 4'hF) $display("note: lane mask ignored");
`endif
        lat = 0;
        do begin
            step();
            lat++;
        end while (!d_valid && lat < 20);
        d_req = 1'b0;
    endtask

    task automatic xact_f(input logic [31:0] a, output int lat,
                          output logic dv_seen);
        if_req  = 1'b1;
        if_addr = a;
        lat     = 0;
        dv_seen = 1'b0;
        do begin
            step();
            lat++;
            dv_seen |= d_valid;
        end while (!if_valid && lat < 20);
        if_req = 1'b0;
    endtask

    initial begin
        int          lat;
        int          dv_at;
        int          iv_at;
        logic        dv_seen;
        logic        any_v;
        logic [5:0]  busy_v;
        logic [31:0] dr_cap;
        logic [31:0] ii_cap;

        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
`ifdef MEM_RESPONDER_BYTE_WE_EN
        d_be    = 4'hF;
`endif
        repeat (2) step();
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_d_valid", {31'b0, d_valid}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        step();

        xact_d(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
        chk("st_lat", lat, 3);
        chk("st_valid", {31'b0, d_valid}, 32'h1);
        chk("st_err", {31'b0, err}, 32'h0);
        chk("st_rdata", d_rdata, 32'h0);

        xact_d(1'b0, 32'h10, 32'h0, 4'hF, lat);
        chk("ld_lat", lat, 3);
        chk("ld_rdata", d_rdata, 32'hDEADBEEF);
        chk("ld_err", {31'b0, err}, 32'h0);
        step();
        chk("ld_pulse_end", {31'b0, d_valid}, 32'h0);
        chk("ld_hold", d_rdata, 32'hDEADBEEF);

        xact_f(32'h10, lat, dv_seen);
        chk("if_lat", lat, 3);
        chk("if_valid", {31'b0, if_valid}, 32'h1);
        chk("if_inst", if_inst, 32'hDEADBEEF);
        chk("if_no_dvalid", {31'b0, dv_seen}, 32'h0);
        chk("if_err", {31'b0, err}, 32'h0);

        // Both requests together: data wins, fetch follows.
        xact_d(1'b1, 32'h0, 32'h0BADC0DE, 4'hF, lat);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        if_req  = 1'b1;
        if_addr = 32'h10;
        dv_at   = 0;
        iv_at   = 0;
        dr_cap  = '0;
        ii_cap  = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            busy_v[k-1] = busy;
            if (d_valid) begin
                dv_at  = k;
                dr_cap = d_rdata;
                d_req  = 1'b0;
            end
            if (if_valid) begin
                iv_at  = k;
                ii_cap = if_inst;
                if_req = 1'b0;
            end
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        chk("arb_d_first", dv_at, 3);
        chk("arb_if_next", iv_at, 6);
        chk("arb_busy", {26'b0, busy_v}, 32'h1B);
        chk("arb_d_data", dr_cap, 32'h0BADC0DE);
        chk("arb_if_data", ii_cap, 32'hDEADBEEF);

        xact_d(1'b0, 32'h12, 32'h0, 4'hF, lat);
        chk("mis_err", {31'b0, err}, 32'h1);
        chk("mis_rdata", d_rdata, 32'h0);
        xact_d(1'b0, 32'h400, 32'h0, 4'hF, lat);
        chk("oor_valid", {31'b0, d_valid}, 32'h1);
        chk("oor_err", {31'b0, err}, 32'h1);
        chk("oor_rdata", d_rdata, 32'h0);
        xact_d(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, lat);
        chk("oor_st_err", {31'b0, err}, 32'h1);
        xact_d(1'b0, 32'h0, 32'h0, 4'hF, lat);
        chk("w0_kept", d_rdata, 32'h0BADC0DE);
        chk("w0_err", {31'b0, err}, 32'h0);
        xact_f(32'h2, lat, dv_seen);
        chk("if_mis_err", {31'b0, err}, 32'h1);
        chk("if_mis_inst", if_inst, 32'h0);

        // Reset lands on the DATA cycle of a store.
        xact_d(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, lat);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'h12345678;
        step();
        chk("rst_mid_busy0", {31'b0, busy}, 32'h1);
        rst   = 1'b1;
        d_req = 1'b0;
        step();
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        any_v = d_valid | if_valid;
        rst   = 1'b0;
        repeat (3) begin
            step();
            any_v |= d_valid | if_valid;
        end
        chk("rst_mid_novalid", {31'b0, any_v}, 32'h0);
        xact_d(1'b0, 32'h20, 32'h0, 4'hF, lat);
        chk("rst_mid_old", d_rdata, 32'hCAFEF00D);

`ifdef MEM_RESPONDER_BYTE_WE_EN
        xact_d(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, lat);
        xact_d(1'b1, 32'h20, 32'h11223344, 4'b0101, lat);
        xact_d(1'b0, 32'h20, 32'h0, 4'hF, lat);
        chk("be_0101", d_rdata, 32'hAA22CC44);
        xact_d(1'b1, 32'h20, 32'h55555555, 4'b0000, lat);
        chk("be_none_valid", {31'b0, d_valid}, 32'h1);
        xact_d(1'b0, 32'h20, 32'h0, 4'hF, lat);
        chk("be_none", d_rdata, 32'hAA22CC44);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
